lane_serializer: RTL

Downstream consumer of the parallel file/sample source. Takes one row of IN_NUM signed lanes, presented in parallel, and emits the lanes one per beat on a valid/ready stream, lane 0 first. It drives the source's enable as a one-cycle fetch pulse, so the source advances exactly one row per serialized row. It sits between the parallel source and single-lane DSP stages such as filters and mixers.

---
 rtl/serializer_pkg.sv | 22 ++
 rtl/lane_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
//   Shared types and helpers for lane_serializer and anything that needs to
//   size a lane index the same way.
//   - state_e : serializer FSM states (2-bit)
//   - lane_w  : lane-index width for a given lane count, clog2 with a floor of 1
//               so a single-lane build still has a 1-bit index port
// -----------------------------------------------------------------------------
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      SEND  = 2'd3
   } state_e;

   function automatic int lane_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lane_serializer.sv
// -----------------------------------------------------------------------------
// lane_serializer
//   Takes one row of IN_NUM signed lanes from a parallel source and emits the
//   lanes one per beat on a valid/ready stream, lane 0 first. The upstream
//   source is advanced with a one-cycle srcEn pulse, exactly once per row.
//
//   Ports
//     clk       system clock
//     rst       synchronous active-high reset
//     en        run enable; gates new row fetches only
//     srcEn     fetch pulse to the upstream source (registered)
//     dataIn    IN_NUM x WIDTH signed row, stable while srcEn is low
//     dataOut   serialized sample (registered)
//     outValid  dataOut valid (registered)
//     outReady  downstream accepts the current beat
//     laneIdx   lane index of dataOut (registered)
//     lastLane  set with the beat carrying lane IN_NUM-1 (registered)
//
//   Row cycle: IDLE -> FETCH (srcEn) -> LOAD (capture dataIn) -> SEND (IN_NUM
//   beats) -> FETCH/IDLE. With outReady held high a row takes IN_NUM+2 cycles.
// -----------------------------------------------------------------------------
module lane_serializer
   import serializer_pkg::*;
#(
   parameter  int WIDTH  = 16,
   parameter  int IN_NUM = 8,
   localparam int LANE_W = lane_w(IN_NUM)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  en,
   output logic                                  srcEn,
   input  logic signed [IN_NUM-1:0][WIDTH-1:0]   dataIn,
   output logic signed [WIDTH-1:0]               dataOut,
   output logic                                  outValid,
   input  logic                                  outReady,
   output logic        [LANE_W-1:0]              laneIdx,
   output logic                                  lastLane
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(IN_NUM - 1);

   state_e                        state_q,     state_d;
   logic [LANE_W-1:0]             lane_q,      lane_d;
   logic [IN_NUM-1:0][WIDTH-1:0]  row_q,       row_d;
   logic                          src_en_q,    src_en_d;
   logic                          out_valid_q, out_valid_d;
   logic [WIDTH-1:0]              data_out_q,  data_out_d;
   logic [LANE_W-1:0]             lane_idx_q,  lane_idx_d;
   logic                          last_lane_q, last_lane_d;
   logic [LANE_W-1:0]             lane_nxt;

   // Every output is computed one cycle ahead so it can be registered: the
   // value written on a state transition is what the new state presents.
   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      row_d       = row_q;
      src_en_d    = 1'b0;
      out_valid_d = out_valid_q;
      data_out_d  = data_out_q;
      lane_idx_d  = lane_idx_q;
      last_lane_d = last_lane_q;
      lane_nxt    = lane_q + LANE_W'(1);

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d  = FETCH;
               src_en_d = 1'b1;
            end
         end

         // srcEn is high during FETCH; the source updates on the edge that
         // ends it, so dataIn is only trusted one cycle later in LOAD.
         FETCH: state_d = LOAD;

         LOAD: begin
            row_d       = dataIn;
            lane_d      = '0;
            state_d     = SEND;
            out_valid_d = 1'b1;
            data_out_d  = dataIn[0];
            lane_idx_d  = '0;
            last_lane_d = (IN_NUM == 1);
         end

         SEND: begin
            // outValid is always high in SEND, so outReady alone marks a beat.
            if (outReady) begin
               if (lane_q == LAST_LANE) begin
                  lane_d      = '0;
                  out_valid_d = 1'b0;
                  data_out_d  = '0;
                  lane_idx_d  = '0;
                  last_lane_d = 1'b0;
                  // en only matters at row boundaries: a drop mid-row lets
                  // the row finish, and the fetch decision is made here.
                  if (en) begin
                     state_d  = FETCH;
                     src_en_d = 1'b1;
                  end else begin
                     state_d  = IDLE;
                  end
               end else begin
                  lane_d      = lane_nxt;
                  data_out_d  = row_q[lane_nxt];
                  lane_idx_d  = lane_nxt;
                  last_lane_d = (lane_nxt == LAST_LANE);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lane_q      <= '0;
         row_q       <= '0;
         src_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         lane_idx_q  <= '0;
         last_lane_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         row_q       <= row_d;
         src_en_q    <= src_en_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         lane_idx_q  <= lane_idx_d;
         last_lane_q <= last_lane_d;
      end
   end

   assign srcEn    = src_en_q;
   assign outValid = out_valid_q;
   assign dataOut  = data_out_q;
   assign laneIdx  = lane_idx_q;
   assign lastLane = last_lane_q;

endmodule
